// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: FSM state encoding,
// the default ack timeout and the wait counter width.
package wb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int WAIT_W          = 16;

endpackage

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone arbiter: round-robin on ties, a mandatory
// idle cycle between grants, and a slave-ack timeout that errors the master.
module wb_arbiter_2to1
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack_i
);

  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic gnt0, gnt1, sel_cyc, sel_stb, timeout;

  // Grants are masked by reset so the bus reads idle while rst_n is held low.
  assign gnt0    = rst_n && (state_q == ST_GRANT0);
  assign gnt1    = rst_n && (state_q == ST_GRANT1);
  assign sel_cyc = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
  assign sel_stb = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);
  assign timeout = sel_cyc & sel_stb & ~s_ack_i & (wait_q == TIMEOUT_VAL);

  always_comb begin
    s_cyc_o  = sel_cyc & ~timeout;
    s_stb_o  = sel_cyc & sel_stb & ~timeout;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_data_o = '0;
    if (gnt0) begin
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
    end else if (gnt1) begin
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
    end
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  // An ack arriving after the master dropped cyc is swallowed here.
  assign m0_ack_o  = gnt0 & m0_cyc_i & s_ack_i;
  assign m1_ack_o  = gnt1 & m1_cyc_i & s_ack_i;
  assign m0_err_o  = gnt0 & timeout;
  assign m1_err_o  = gnt1 & timeout;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d      = last_grant_q ? ST_GRANT0 : ST_GRANT1;
          last_grant_d = ~last_grant_q;
        end else if (m0_cyc_i) begin
          state_d      = ST_GRANT0;
          last_grant_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = ST_GRANT1;
          last_grant_d = 1'b1;
        end
      end
      ST_GRANT0: if (!m0_cyc_i || timeout) state_d = ST_IDLE;
      ST_GRANT1: if (!m1_cyc_i || timeout) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if ((state_d != state_q) || s_ack_i || !s_stb_o) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1 with a 4-cycle timeout; expected values
// are hand-computed per cycle.
module tb_wb_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_sel_i (m0_sel_i),
    .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_sel_i (m1_sel_i),
    .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic m0_req(input logic cyc, input logic we, input logic [31:0] addr);
    m0_cyc_i  = cyc;
    m0_stb_i  = cyc;
    m0_we_i   = we;
    m0_addr_i = addr;
    m0_sel_i  = 4'hF;
    m0_data_i = 32'h0000_0000;
  endtask

  task automatic m1_req(input logic cyc, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel);
    m1_cyc_i  = cyc;
    m1_stb_i  = cyc;
    m1_we_i   = we;
    m1_addr_i = addr;
    m1_data_i = data;
    m1_sel_i  = sel;
  endtask

  initial begin
    rst_n    = 1'b0;
    s_ack_i  = 1'b0;
    s_data_i = 32'hA5A5_A5A5;
    m0_req(1'b1, 1'b0, 32'h10);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    #1;
    check("rst_s_cyc",   s_cyc_o,   1'b0);
    check("rst_s_stb",   s_stb_o,   1'b0);
    check("rst_s_addr",  s_addr_o,  32'h0);
    check("rst_m0_ack",  m0_ack_o,  1'b0);
    check("rst_m0_err",  m0_err_o,  1'b0);
    check("rst_m1_ack",  m1_ack_o,  1'b0);
    check("rst_m0_data", m0_data_o, 32'hA5A5_A5A5);
    check("rst_m1_data", m1_data_o, 32'hA5A5_A5A5);
    $display("[tb] reset: outputs idle, read data follows slave");

    // Tie straight after reset: m0, idle gap, m1, then the next tie to m0.
    rst_n = 1'b1;
    m1_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    #1;
    check("tie_idle_cyc", s_cyc_o, 1'b0);
    step(); #1;
    check("tie1_cyc",  s_cyc_o,  1'b1);
    check("tie1_addr", s_addr_o, 32'h10);
    s_ack_i = 1'b1; #1;
    check("tie1_m0_ack", m0_ack_o, 1'b1);
    check("tie1_m1_ack", m1_ack_o, 1'b0);
    step();
    s_ack_i = 1'b0;
    m0_req(1'b0, 1'b0, 32'h10);
    #1;
    check("tie1_drop_cyc", s_cyc_o, 1'b0);
    step(); #1;
    check("tie_gap_cyc", s_cyc_o, 1'b0);
    step(); #1;
    check("tie2_cyc",  s_cyc_o,  1'b1);
    check("tie2_addr", s_addr_o, 32'h20);
    s_ack_i = 1'b1; #1;
    check("tie2_m1_ack", m1_ack_o, 1'b1);
    check("tie2_m0_ack", m0_ack_o, 1'b0);
    step();
    s_ack_i = 1'b0;
    m1_req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
    step();
    m0_req(1'b1, 1'b0, 32'h10);
    m1_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    step(); #1;
    check("tie3_addr", s_addr_o, 32'h10);
    m0_req(1'b0, 1'b0, 32'h0);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    $display("[tb] tie: m0 then m1 then m0");

    // m0 read, slave acks on the third granted cycle.
    m0_req(1'b1, 1'b0, 32'h100);
    #1;
    check("rd_latency_cyc", s_cyc_o, 1'b0);
    step(); #1;
    check("rd_cyc",    s_cyc_o,  1'b1);
    check("rd_addr",   s_addr_o, 32'h100);
    check("rd_we",     s_we_o,   1'b0);
    check("rd_early_ack", m0_ack_o, 1'b0);
    step();
    step();
    s_ack_i  = 1'b1;
    s_data_i = 32'hDEAD_BEEF;
    #1;
    check("rd_m0_ack",  m0_ack_o,  1'b1);
    check("rd_m0_data", m0_data_o, 32'hDEAD_BEEF);
    check("rd_m1_ack",  m1_ack_o,  1'b0);
    check("rd_m1_data", m1_data_o, 32'hDEAD_BEEF);
    m0_req(1'b0, 1'b0, 32'h100);
    #1;
    check("late_ack_m0", m0_ack_o, 1'b0);
    check("late_ack_cyc", s_cyc_o, 1'b0);
    s_ack_i = 1'b0;
    step();
    $display("[tb] m0 read 0x100 -> 0xdeadbeef");

    // m1 write with partial byte selects.
    m1_req(1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011);
    step(); #1;
    check("wr_we",   s_we_o,   1'b1);
    check("wr_stb",  s_stb_o,  1'b1);
    check("wr_addr", s_addr_o, 32'h2000);
    check("wr_data", s_data_o, 32'h1234_5678);
    check("wr_sel",  s_sel_o,  4'b0011);
    s_ack_i = 1'b1; #1;
    check("wr_m1_ack", m1_ack_o, 1'b1);
    check("wr_m0_ack", m0_ack_o, 1'b0);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ack_i = 1'b0;
    step();
    $display("[tb] m1 write 0x2000 <- 0x12345678 sel 0x3");

    // Slave never acks: four wait cycles, then a one-cycle err.
    m0_req(1'b1, 1'b0, 32'h300);
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_wait_cyc", s_cyc_o,  1'b1);
      check("to_wait_err", m0_err_o, 1'b0);
      step();
    end
    #1;
    check("to_err",   m0_err_o, 1'b1);
    check("to_s_cyc", s_cyc_o,  1'b0);
    check("to_s_stb", s_stb_o,  1'b0);
    check("to_m1_err", m1_err_o, 1'b0);
    step(); #1;
    check("to_idle_cyc", s_cyc_o,  1'b0);
    check("to_idle_err", m0_err_o, 1'b0);
    step(); #1;
    check("to_regrant_cyc", s_cyc_o, 1'b1);
    $display("[tb] m0 timeout after 4 wait cycles, re-granted");

    // Same master, ack lands exactly on the timeout cycle.
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ackto_wait_err", m0_err_o, 1'b0);
      step();
    end
    s_ack_i = 1'b1; #1;
    check("ackto_ack", m0_ack_o, 1'b1);
    check("ackto_err", m0_err_o, 1'b0);
    check("ackto_cyc", s_cyc_o,  1'b1);
    step();
    s_ack_i = 1'b0; #1;
    check("ackto_after_err", m0_err_o, 1'b0);
    check("ackto_after_cyc", s_cyc_o,  1'b1);
    m0_req(1'b0, 1'b0, 32'h0);
    step();
    $display("[tb] ack on timeout cycle wins");

    // Reset during a GRANT1 transfer, then a tie.
    m1_req(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    step(); #1;
    check("rg_cyc", s_cyc_o, 1'b1);
    rst_n = 1'b0;
    step(); #1;
    check("rg_abort_cyc", s_cyc_o,  1'b0);
    check("rg_abort_err", m1_err_o, 1'b0);
    check("rg_abort_ack", m1_ack_o, 1'b0);
    rst_n = 1'b1;
    m0_req(1'b1, 1'b0, 32'h10);
    #1;
    check("rg_idle_cyc", s_cyc_o, 1'b0);
    step(); #1;
    check("rg_tie_addr", s_addr_o, 32'h10);
    check("rg_tie_cyc",  s_cyc_o,  1'b1);
    m0_req(1'b0, 1'b0, 32'h0);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    $display("[tb] reset in GRANT1 aborts, next tie to m0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
